// File: rtl/mips_isa_pkg.sv
// MIPS ISA encodings shared by the instruction encoder and the control decoder.
package mips_isa_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_SLT,
        OP_JR,
        OP_LW,
        OP_SW,
        OP_BEQ,
        OP_BNE,
        OP_BGEZ,
        OP_BGTZ,
        OP_BLEZ,
        OP_BLTZ,
        OP_ADDI,
        OP_ANDI,
        OP_ORI,
        OP_J,
        OP_JAL
    } op_sel_e;

    localparam int NUM_OPS = 19;

    localparam logic [5:0] OPC_RTYPE  = 6'b000000;
    localparam logic [5:0] OPC_REGIMM = 6'b000001;
    localparam logic [5:0] OPC_J      = 6'b000010;
    localparam logic [5:0] OPC_JAL    = 6'b000011;
    localparam logic [5:0] OPC_BEQ    = 6'b000100;
    localparam logic [5:0] OPC_BNE    = 6'b000101;
    localparam logic [5:0] OPC_BLEZ   = 6'b000110;
    localparam logic [5:0] OPC_BGTZ   = 6'b000111;
    localparam logic [5:0] OPC_ADDI   = 6'b001000;
    localparam logic [5:0] OPC_ANDI   = 6'b001100;
    localparam logic [5:0] OPC_ORI    = 6'b001101;
    localparam logic [5:0] OPC_LW     = 6'b100011;
    localparam logic [5:0] OPC_SW     = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // rt doubles as a sub-opcode for REGIMM branches; BGTZ/BLEZ require it zero
    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;
    localparam logic [4:0] RT_ZERO = 5'b00000;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] target;
    } instr_fields_t;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {OPC_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] opc, input logic [25:0] target);
        return {opc, target};
    endfunction

endpackage

// File: rtl/instr_word_pack.sv
// Combinational mnemonic-to-word packer; zero latency, no flow control.
module instr_word_pack
    import mips_isa_pkg::*;
(
    input  logic [4:0]    op_sel,
    input  instr_fields_t fields,
    output logic [31:0]   word,
    output logic          legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (op_sel_e'(op_sel))
            OP_ADD:  word = enc_r(fields.rs, fields.rt, fields.rd, FN_ADD);
            OP_SUB:  word = enc_r(fields.rs, fields.rt, fields.rd, FN_SUB);
            OP_AND:  word = enc_r(fields.rs, fields.rt, fields.rd, FN_AND);
            OP_OR:   word = enc_r(fields.rs, fields.rt, fields.rd, FN_OR);
            OP_SLT:  word = enc_r(fields.rs, fields.rt, fields.rd, FN_SLT);
            OP_JR:   word = enc_r(fields.rs, 5'd0, 5'd0, FN_JR);
            OP_LW:   word = enc_i(OPC_LW, fields.rs, fields.rt, fields.imm);
            OP_SW:   word = enc_i(OPC_SW, fields.rs, fields.rt, fields.imm);
            OP_BEQ:  word = enc_i(OPC_BEQ, fields.rs, fields.rt, fields.imm);
            OP_BNE:  word = enc_i(OPC_BNE, fields.rs, fields.rt, fields.imm);
            // single-register branches ignore the rt input entirely
            OP_BGEZ: word = enc_i(OPC_REGIMM, fields.rs, RT_BGEZ, fields.imm);
            OP_BGTZ: word = enc_i(OPC_BGTZ, fields.rs, RT_ZERO, fields.imm);
            OP_BLEZ: word = enc_i(OPC_BLEZ, fields.rs, RT_ZERO, fields.imm);
            OP_BLTZ: word = enc_i(OPC_REGIMM, fields.rs, RT_BLTZ, fields.imm);
            OP_ADDI: word = enc_i(OPC_ADDI, fields.rs, fields.rt, fields.imm);
            OP_ANDI: word = enc_i(OPC_ANDI, fields.rs, fields.rt, fields.imm);
            OP_ORI:  word = enc_i(OPC_ORI, fields.rs, fields.rt, fields.imm);
            OP_J:    word = enc_j(OPC_J, fields.target);
            OP_JAL:  word = enc_j(OPC_JAL, fields.target);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes one instruction per handshake and writes it to imem at an auto-incrementing address.
// imem_we rises the cycle after accept; in_ready is low while a write awaits imem_ack, on rewind, or when full.
module instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              rewind,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              bad_op,
    output logic              full,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_FULL
    } state_t;

    state_t        state;
    instr_fields_t fields;
    logic [31:0]   packed_word;
    logic          packed_legal;

    assign fields = '{rs: rs, rt: rt, rd: rd, imm: imm, target: target};

    instr_word_pack u_pack (
        .op_sel (op_sel),
        .fields (fields),
        .word   (packed_word),
        .legal  (packed_legal)
    );

    // rewind takes priority over a same-cycle instruction
    assign in_ready = (state == S_IDLE) && !rewind && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= '0;
            bad_op     <= 1'b0;
            full       <= 1'b0;
            count      <= '0;
        end else begin
            bad_op <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rewind) begin
                        imem_addr <= BASE;
                        count     <= '0;
                        full      <= 1'b0;
                    end else if (in_valid) begin
                        if (packed_legal) begin
                            imem_wdata <= packed_word;
                            imem_we    <= 1'b1;
                            state      <= S_WRITE;
                        end else begin
                            bad_op <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (imem_ack) begin
                        imem_we <= 1'b0;
                        count   <= count + (ADDR_W+1)'(1);
                        if (imem_addr == LAST) begin
                            full  <= 1'b1;
                            state <= S_FULL;
                        end else begin
                            imem_addr <= imem_addr + ADDR_W'(1);
                            state     <= S_IDLE;
                        end
                    end
                end
                S_FULL: begin
                    if (rewind) begin
                        imem_addr <= BASE;
                        count     <= '0;
                        full      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: randomized instructions vs. a field-level MIPS encoding model.
module tb_instr_encoder;

    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          rewind = 1'b0;
    logic          imem_ack = 1'b0;
    logic [4:0]    op_sel = '0, rs = '0, rt = '0, rd = '0;
    logic [15:0]   imm = '0;
    logic [25:0]   target = '0;
    logic          in_ready, imem_we, bad_op, full;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_sel     (op_sel),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm        (imm),
        .target     (target),
        .rewind     (rewind),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_ack   (imem_ack),
        .bad_op     (bad_op),
        .full       (full),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] word;
        int          cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   model_cnt = 0;
    int   bad_issued = 0;
    int   bad_seen = 0;
    int   ack_mode = 0;   // 0 always ack, 1 random, 2 withhold

    int opc_tab [19] = '{0, 0, 0, 0, 0, 0, 35, 43, 4, 5, 1, 7, 6, 1, 8, 12, 13, 2, 3};
    int fn_tab  [5]  = '{32, 34, 36, 37, 42};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int op, input logic [4:0] s, input logic [4:0] t,
                                             input logic [4:0] d, input logic [15:0] im,
                                             input logic [25:0] tg);
        logic [31:0] w;
        if (op <= 4)
            w = {6'd0, s, t, d, 5'd0, 6'(fn_tab[op])};
        else if (op == 5)
            w = {6'd0, s, 15'd0, 6'd8};
        else if (op >= 17)
            w = {6'(opc_tab[op]), tg};
        else if (op >= 10 && op <= 13)
            w = {6'(opc_tab[op]), s, (op == 10) ? 5'd1 : 5'd0, im};
        else
            w = {6'(opc_tab[op]), s, t, im};
        return w;
    endfunction

    initial forever begin
        @(posedge clk);
        #2;
        case (ack_mode)
            0:       imem_ack = 1'b1;
            1:       imem_ack = ($urandom_range(0, 2) != 0);
            default: imem_ack = 1'b0;
        endcase
    end

    // Monitor: every acked write must match the head of the scoreboard
    logic          prev_we = 1'b0, prev_ack = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [31:0]   prev_wdata = '0;
    initial forever begin
        @(negedge clk);
        if (reset) begin
            prev_we = 1'b0;
        end else begin
            if (prev_we && !prev_ack) begin
                chk("hold_we", imem_we, 1'b1);
                chk("hold_addr", imem_addr, prev_addr);
                chk("hold_wdata", imem_wdata, prev_wdata);
            end
            if (imem_we) begin
                chk("ready_low_in_write", in_ready, 1'b0);
                if (imem_ack) begin
                    chk("write_expected", sb.size() > 0, 1'b1);
                    if (sb.size() > 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("wr_addr", imem_addr, e.addr);
                        chk("wr_data", imem_wdata, e.word);
                        chk("wr_count_before", count, e.cnt);
                    end
                end
            end
            if (bad_op) bad_seen++;
            prev_we    = imem_we;
            prev_ack   = imem_ack;
            prev_addr  = imem_addr;
            prev_wdata = imem_wdata;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (imem_we && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", imem_we, 1'b0);
    endtask

    task automatic send(input int op, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                        input logic [15:0] im, input logic [25:0] tg, input bit track);
        int waited = 0;
        op_sel = 5'(op); rs = s; rt = t; rd = d; imm = im; target = tg;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("accept_timeout", in_ready, 1'b1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        if (op < 19) begin
            if (track) begin
                sb.push_back('{model_cnt, ref_word(op, s, t, d, im, tg), model_cnt});
                model_cnt++;
            end
        end else begin
            bad_issued++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        op_sel = 5'($urandom); rt = 5'($urandom);
        if (op >= 19) begin
            chk("bad_pulse", bad_op, 1'b1);
            chk("bad_no_we", imem_we, 1'b0);
            chk("bad_ready_stays", in_ready, 1'b1);
            chk("bad_count_same", count, model_cnt);
            @(negedge clk);
            chk("bad_one_cycle", bad_op, 1'b0);
        end
    endtask

    task automatic do_rewind();
        wait_idle();
        rewind = 1'b1;
        in_valid = 1'b1;
        op_sel = 5'd0;
        #1;
        chk("rewind_blocks_ready", in_ready, 1'b0);
        @(negedge clk);
        rewind = 1'b0;
        in_valid = 1'b0;
        chk("rewind_no_we", imem_we, 1'b0);
        chk("rewind_addr", imem_addr, 0);
        chk("rewind_count", count, 0);
        chk("rewind_full", full, 1'b0);
        model_cnt = 0;
    endtask

    task automatic full_test();
        wait_idle();
        chk("full_flag", full, 1'b1);
        chk("full_count", count, DEPTH);
        chk("full_addr_last", imem_addr, DEPTH - 1);
        in_valid = 1'b1;
        op_sel = 5'd14;
        repeat (3) begin
            #1;
            chk("full_ready_low", in_ready, 1'b0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        do_rewind();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_we", imem_we, 1'b0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 32'h0);
        chk("rst_bad_op", bad_op, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_count", count, 0);
        #1 reset = 1'b0;
        #1 chk("ready_after_reset", in_ready, 1'b1);
        @(negedge clk);

        // ADDI with immediate ack
        send(14, 5'd1, 5'd2, 5'd0, 16'h0005, 26'd0, 1'b1);
        chk("addi_we", imem_we, 1'b1);
        chk("addi_word", imem_wdata, 32'h20220005);
        chk("addi_addr", imem_addr, 0);
        @(negedge clk);
        chk("addi_ready_n2", in_ready, 1'b1);
        chk("addi_count", count, 1);

        send(0, 5'd1, 5'd2, 5'd3, 16'h0, 26'd0, 1'b1);
        chk("add_word", imem_wdata, 32'h00221820);
        wait_idle();
        send(5, 5'd31, 5'd9, 5'd9, 16'h1234, 26'd0, 1'b1);
        chk("jr_word", imem_wdata, 32'h03E00008);
        wait_idle();
        send(10, 5'd4, 5'd7, 5'd0, 16'hFFFE, 26'd0, 1'b1);
        chk("bgez_word", imem_wdata, 32'h0481FFFE);
        wait_idle();
        send(18, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010, 1'b1);
        chk("jal_word", imem_wdata, 32'h0C000010);
        wait_idle();

        // ack withheld for three cycles
        ack_mode = 2;
        send(1, 5'd5, 5'd6, 5'd7, 16'h0, 26'd0, 1'b1);
        repeat (3) @(negedge clk);
        chk("stall_count_held", count, model_cnt - 1);
        ack_mode = 0;
        wait_idle();
        chk("stall_single_incr", count, model_cnt);

        // invalid op then LW at the same address
        send(25, 5'd1, 5'd1, 5'd1, 16'h1, 26'd1, 1'b1);
        send(6, 5'd0, 5'd8, 5'd0, 16'h0004, 26'd0, 1'b1);
        chk("lw_word", imem_wdata, 32'h8C080004);
        chk("lw_addr_after_bad", imem_addr, 6);
        wait_idle();

        ack_mode = 1;
        for (int i = 0; i < 300; i++) begin
            int op;
            if (model_cnt == DEPTH) full_test();
            if (model_cnt > 0 && $urandom_range(0, 24) == 0) do_rewind();
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(19, 31)) : int'($urandom_range(0, 18));
            send(op, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        if (model_cnt == DEPTH) full_test();

        // reset in the middle of a write
        ack_mode = 2;
        send(14, 5'd3, 5'd4, 5'd0, 16'h00AA, 26'd0, 1'b0);
        chk("rst_mid_we_before", imem_we, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_we_dropped", imem_we, 1'b0);
        chk("rst_mid_count", count, 0);
        chk("rst_mid_addr", imem_addr, 0);
        #1 reset = 1'b0;
        model_cnt = 0;
        ack_mode = 0;
        @(negedge clk);
        send(3, 5'd9, 5'd10, 5'd11, 16'h0, 26'd0, 1'b1);
        wait_idle();
        chk("post_reset_count", count, 1);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        chk("bad_op_pulses", bad_seen, bad_issued);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
